// File: rtl/sobel_window_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_stream_pkg : shared constants and types for the window streamer |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package sobel_window_stream_pkg;

  localparam logic MODE_SKIP = 1'b0;
  localparam logic MODE_ZERO = 1'b1;

  localparam int WIN_DIM = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sobel_window_stream_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_stream_line_buffer : two-row line store, async read, sync write |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module sobel_window_stream_line_buffer #(
  parameter int DEPTH  = 160,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  // Both rows share one word so a single RAM macro holds the whole history.
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign rd_data_o = r_mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[addr_i] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_window_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sobel_window_stream : raster pixel stream to 3x3 Sobel windows, with borders |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module sobel_window_stream
  import sobel_window_stream_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120
) (
  input  logic                     clk_i,
  input  logic                     nreset_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     in_valid_i,
  input  logic [PIXEL_WIDTH-1:0]   in_px_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [9*PIXEL_WIDTH-1:0] out_window_o,
  output logic                     out_border_o,
  output logic                     out_eof_o,
  output logic                     busy_o,
  output logic                     frame_done_o
);

  localparam int c_col_w = $clog2(IMG_WIDTH);
  localparam int c_row_w = $clog2(IMG_HEIGHT);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);

  // Element (i,j) sits at bits (8-3i-j)*PIXEL_WIDTH, matching the sobel_core matrix.
  typedef logic [0:WIN_DIM-1][0:WIN_DIM-1][PIXEL_WIDTH-1:0] window_t;
  typedef logic [0:WIN_DIM-1][0:WIN_DIM-2][PIXEL_WIDTH-1:0] hist_t;

  generate
    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_geometry
      $error("sobel_window_stream: IMG_WIDTH and IMG_HEIGHT must both be >= 3");
    end
  endgenerate

  state_e                   r_state;
  state_e                   w_state_next;
  logic                     r_mode;
  logic [c_col_w-1:0]       r_col;
  logic [c_row_w-1:0]       r_row;
  hist_t                    r_hist;
  window_t                  w_win_next;
  logic                     r_out_valid;
  logic [9*PIXEL_WIDTH-1:0] r_out_window;
  logic                     r_out_border;
  logic                     r_out_eof;
  logic                     r_frame_done;
  logic                     w_frame_done;
  logic                     w_start;
  logic                     w_out_free;
  logic                     w_accept;
  logic                     w_interior;
  logic                     w_last;
  logic                     w_load;
  logic [2*PIXEL_WIDTH-1:0] w_lb_rd;
  logic [PIXEL_WIDTH-1:0]   w_tap_a;
  logic [PIXEL_WIDTH-1:0]   w_tap_b;

  assign w_start    = (r_state == ST_IDLE) && start_i;
  assign w_out_free = !r_out_valid || out_ready_i;
  assign in_ready_o = (r_state == ST_RUN) && w_out_free;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_interior = (r_row >= c_row_w'(2)) && (r_col >= c_col_w'(2));
  assign w_last     = (r_row == c_row_last) && (r_col == c_col_last);
  assign w_load     = w_accept && ((r_mode == MODE_ZERO) || w_interior);

  sobel_window_stream_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2 * PIXEL_WIDTH)
  ) u_line_buffer (
    .clk_i     (clk_i),
    .addr_i    (r_col),
    .wr_en_i   (w_accept),
    .wr_data_i ({w_tap_b, in_px_i}),
    .rd_data_o (w_lb_rd)
  );

  assign w_tap_a = w_lb_rd[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
  assign w_tap_b = w_lb_rd[PIXEL_WIDTH-1:0];

  // The two older columns come from history; the new right column is {a, b, p}.
  always_comb begin
    w_win_next = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      w_win_next[i][0] = r_hist[i][0];
      w_win_next[i][1] = r_hist[i][1];
    end
    w_win_next[0][2] = w_tap_a;
    w_win_next[1][2] = w_tap_b;
    w_win_next[2][2] = in_px_i;
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept && w_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_free) begin
          w_state_next = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
      r_mode       <= MODE_SKIP;
      r_col        <= '0;
      r_row        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_frame_done;
      if (w_start) begin
        r_mode <= mode_i;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_accept) begin
        if (r_col == c_col_last) begin
          r_col <= '0;
          r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_hist <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < WIN_DIM; i++) begin
        r_hist[i][0] <= r_hist[i][1];
        r_hist[i][1] <= w_win_next[i][2];
      end
    end
  end

  // Single output stage: in_ready guarantees it is empty or draining when loaded.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_border <= 1'b0;
      r_out_eof    <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_window <= w_interior ? w_win_next : '0;
      r_out_border <= !w_interior;
      r_out_eof    <= w_last;
    end else if (out_ready_i) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid_o  = r_out_valid;
  assign out_window_o = r_out_window;
  assign out_border_o = r_out_border;
  assign out_eof_o    = r_out_eof;
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sobel_window_stream : directed bench, 5x4 frames with pixel = 5r+c        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_sobel_window_stream;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        start_i;
  logic        mode_i;
  logic        in_valid_i;
  logic [7:0]  in_px_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [71:0] out_window_o;
  logic        out_border_o;
  logic        out_eof_o;
  logic        busy_o;
  logic        frame_done_o;

  sobel_window_stream #(
    .PIXEL_WIDTH (8),
    .IMG_WIDTH   (5),
    .IMG_HEIGHT  (4)
  ) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .in_valid_i   (in_valid_i),
    .in_px_i      (in_px_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_window_o (out_window_o),
    .out_border_o (out_border_o),
    .out_eof_o    (out_eof_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [71:0] cap_win[$];
  logic        cap_border[$];
  logic        cap_eof[$];
  int          done_cnt;
  bit          seen_valid;
  int          first_valid_cyc;
  int          acc_cyc[20];
  bit          ok;
  bit          bp_seen;
  logic [71:0] snap;
  int          n_border;

  localparam logic [71:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
  localparam logic [71:0] LAST_WIN  = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};

  always @(posedge clk_i) cyc <= cyc + 1;

  // Handshakes complete at the next rising edge; inputs are stable from here to it.
  always @(negedge clk_i) begin
    if (out_valid_o && out_ready_i) begin
      cap_win.push_back(out_window_o);
      cap_border.push_back(out_border_o);
      cap_eof.push_back(out_eof_o);
    end
    if (frame_done_o) done_cnt++;
    if (out_valid_o && !seen_valid) begin
      seen_valid      = 1'b1;
      first_valid_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window centred on (r-1, c-1): rows r-2..r, cols c-2..c, value 5*row+col+off.
  function automatic logic [71:0] exp_win(input int r, input int c, input int off);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[(8-k)*8 +: 8] = 8'(5*(r-2+k/3) + (c-2+k%3) + off);
    return w;
  endfunction

  task automatic clear_caps();
    cap_win.delete();
    cap_border.delete();
    cap_eof.delete();
    seen_valid = 1'b0;
    done_cnt   = 0;
  endtask

  task automatic do_start(input logic m);
    start_i = 1'b1;
    mode_i  = m;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    mode_i  = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_max, input int off);
    int  waited;
    bit  tmo;
    tmo = 1'b0;
    for (int i = 0; i < n && !tmo; i++) begin
      if (gap_max > 0) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk_i); #1; end
      end
      in_px_i    = 8'(i + off);
      in_valid_i = 1'b1;
      waited     = 0;
      forever begin
        @(negedge clk_i);
        if (in_ready_o) break;
        waited++;
        if (waited > 50) break;
      end
      if (waited > 50) tmo = 1'b1;
      acc_cyc[i] = cyc + 1;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    check("feed_no_timeout", tmo, 1'b0);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (frame_done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_skip_frame(input string tag, input int off);
    check({tag, "_count"}, cap_win.size(), 6);
    for (int k = 0; k < 6 && k < cap_win.size(); k++) begin
      check($sformatf("%s_win%0d", tag, k), cap_win[k], exp_win(2 + k/3, 2 + k%3, off));
      check($sformatf("%s_border%0d", tag, k), cap_border[k], 1'b0);
      check($sformatf("%s_eof%0d", tag, k), cap_eof[k], logic'(k == 5));
    end
  endtask

  initial begin
    nreset_i    = 1'b0;
    start_i     = 1'b0;
    mode_i      = 1'b0;
    in_valid_i  = 1'b0;
    in_px_i     = '0;
    out_ready_i = 1'b1;
    clear_caps();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_window", out_window_o, 72'd0);
    check("rst_border", out_border_o, 1'b0);
    check("rst_eof", out_eof_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_frame_done", frame_done_o, 1'b0);
    @(posedge clk_i); #1;
    nreset_i = 1'b1;
    @(posedge clk_i); #1;
    check("idle_in_ready", in_ready_o, 1'b0);

    // 1: SKIP frame
    clear_caps();
    do_start(1'b0);
    check("t1_busy", busy_o, 1'b1);
    feed(20, 0, 0);
    wait_done(ok);
    check("t1_done_seen", ok, 1'b1);
    check("t1_busy_low", busy_o, 1'b0);
    @(negedge clk_i);
    check("t1_done_single", frame_done_o, 1'b0);
    check("t1_done_cnt", done_cnt, 1);
    check_skip_frame("t1", 0);
    if (cap_win.size() == 6) begin
      check("t1_first_literal", cap_win[0], FIRST_WIN);
      check("t1_last_literal", cap_win[5], LAST_WIN);
    end
    check("t1_latency", first_valid_cyc, acc_cyc[12]);

    // 2: ZERO frame
    clear_caps();
    do_start(1'b1);
    feed(20, 0, 0);
    wait_done(ok);
    check("t2_done_seen", ok, 1'b1);
    check("t2_count", cap_win.size(), 20);
    n_border = 0;
    for (int i = 0; i < 20 && i < cap_win.size(); i++) begin
      if (cap_border[i]) n_border++;
      if ((i / 5) >= 2 && (i % 5) >= 2) begin
        check($sformatf("t2_win%0d", i), cap_win[i], exp_win(i / 5, i % 5, 0));
        check($sformatf("t2_border%0d", i), cap_border[i], 1'b0);
      end else begin
        check($sformatf("t2_win%0d", i), cap_win[i], 72'd0);
        check($sformatf("t2_border%0d", i), cap_border[i], 1'b1);
      end
      check($sformatf("t2_eof%0d", i), cap_eof[i], logic'(i == 19));
    end
    check("t2_border_total", n_border, 14);

    // 3: backpressure right after the first window
    clear_caps();
    bp_seen = 1'b0;
    do_start(1'b0);
    fork
      feed(20, 0, 0);
      begin
        for (int k = 0; k < 200 && !bp_seen; k++) begin
          @(posedge clk_i); #1;
          if (out_valid_o) bp_seen = 1'b1;
        end
        check("t3_first_valid", bp_seen, 1'b1);
        out_ready_i = 1'b0;
        snap = out_window_o;
        check("t3_snap", snap, exp_win(2, 2, 0));
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          check($sformatf("t3_in_ready%0d", k), in_ready_o, 1'b0);
          check($sformatf("t3_valid%0d", k), out_valid_o, 1'b1);
          check($sformatf("t3_hold%0d", k), out_window_o, snap);
          @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
      end
    join
    wait_done(ok);
    check("t3_done_seen", ok, 1'b1);
    check_skip_frame("t3", 0);

    // 4: start with mode toggled mid-frame is ignored
    clear_caps();
    do_start(1'b0);
    fork
      feed(20, 0, 0);
      begin
        repeat (8) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        mode_i  = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        check("t4_busy", busy_o, 1'b1);
      end
    join
    wait_done(ok);
    check("t4_done_seen", ok, 1'b1);
    check_skip_frame("t4", 0);

    // 5: reset after 9 accepts, then a clean frame
    clear_caps();
    do_start(1'b0);
    feed(9, 0, 0);
    nreset_i = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready_o, 1'b0);
    check("t5_rst_valid", out_valid_o, 1'b0);
    check("t5_rst_window", out_window_o, 72'd0);
    check("t5_rst_border", out_border_o, 1'b0);
    check("t5_rst_eof", out_eof_o, 1'b0);
    check("t5_rst_busy", busy_o, 1'b0);
    check("t5_rst_done", frame_done_o, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    nreset_i = 1'b1;
    clear_caps();
    do_start(1'b0);
    feed(20, 0, 0);
    wait_done(ok);
    check("t5_done_seen", ok, 1'b1);
    check_skip_frame("t5", 0);

    // 6: back-to-back frames with gapped input, second frame offset by 100
    clear_caps();
    do_start(1'b0);
    feed(20, 3, 0);
    wait_done(ok);
    check("t6a_done_seen", ok, 1'b1);
    check_skip_frame("t6a", 0);
    clear_caps();
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("t6_restart_busy", busy_o, 1'b1);
    feed(20, 3, 100);
    wait_done(ok);
    check("t6b_done_seen", ok, 1'b1);
    check_skip_frame("t6b", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
